// File: rtl/multdiv_pkg.sv
// multdiv_pkg: shared types and constants for the iterative multiply/divide unit.
//   state_e   : sequencer states (IDLE/RUN/FIX/DONE)
//   op_e      : operation latched at start (OP_MUL/OP_DIV)
//   ITER_*    : RUN-phase iteration counts per operation
//   INT_MIN   : most negative 32-bit value (divide overflow detection)
//   mul_limit : terminal counter value for multiply, radix-2 or radix-4
package multdiv_pkg;
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_e;
  typedef enum logic {OP_MUL, OP_DIV} op_e;

  localparam int ITER_MUL    = 32;
  localparam int ITER_MUL_R4 = 16;
  localparam int ITER_DIV    = 32;

  localparam logic [31:0] INT_MIN = 32'h8000_0000;

  function automatic logic [5:0] mul_limit(input logic r4);
    return r4 ? 6'(ITER_MUL_R4 - 1) : 6'(ITER_MUL - 1);
  endfunction
endpackage

// File: rtl/multdiv_counter.sv
// multdiv_counter: iteration counter shared by the multiply and divide datapaths.
//   clock, ctrl_reset : clock, async active-high reset
//   clr               : restart count at 0 (priority over en)
//   en                : advance one step
//   limit             : runtime terminal value
//   tc                : count == limit; the counter holds there (no wrap)
module multdiv_counter #(
  parameter int CW = 6
) (
  input  logic          clock,
  input  logic          ctrl_reset,
  input  logic          clr,
  input  logic          en,
  input  logic [CW-1:0] limit,
  output logic          tc
);
  logic [CW-1:0] count;

  assign tc = (count == limit);

  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset)       count <= '0;
    else if (clr)         count <= '0;
    else if (en && !tc)   count <= count + 1'b1;
  end
endmodule

// File: rtl/multdiv_unit.sv
// multdiv_unit: iterative signed multiply (Booth) / divide (restoring) unit.
//   clock, ctrl_reset          : clock, async active-high reset
//   ctrl_MULT, ctrl_DIV        : one-cycle start pulses (MULT wins if both high);
//                                a start in any state restarts with new operands
//   data_operandA/B            : operands, sampled on the start edge
//   data_result, data_exception: registered, updated only on entry to DONE
//   data_resultRDY             : one-cycle pulse while in DONE
//   busy                       : high in RUN and FIX
// Build option: define MULTDIV_RADIX4_EN for radix-4 Booth multiply (16 steps).
module multdiv_unit
  import multdiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITER  = ITER_DIV
) (
  input  logic             clock,
  input  logic             ctrl_reset,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);
  // Two guard bits above the accumulator: acc +/- 2M must not wrap before the shift.
  localparam int AW = WIDTH + 2;
`ifdef MULTDIV_RADIX4_EN
  localparam logic R4 = 1'b1;
`else
  localparam logic R4 = 1'b0;
`endif
  localparam logic [5:0] MUL_LIM = mul_limit(R4);
  localparam logic [5:0] DIV_LIM = 6'(ITER - 1);

  state_e                  state;
  op_e                     op;
  logic signed [AW-1:0]    acc, acc_mul, acc_div, mx, sum;
  logic        [WIDTH-1:0] q, q_mul, q_div, m;
  logic                    qm1, qm1_mul, neg, div_ovf, mul_exc, tc, start;
  logic        [WIDTH:0]   rem_sh, diff;

  assign start = ctrl_MULT | ctrl_DIV;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

  multdiv_counter #(.CW(6)) u_cnt (
    .clock      (clock),
    .ctrl_reset (ctrl_reset),
    .clr        (start),
    .en         (state == RUN),
    .limit      ((op == OP_MUL) ? MUL_LIM : DIV_LIM),
    .tc         (tc)
  );

  // Booth step over {acc, q, qm1}: add/sub a multiple of M, then arithmetic shift.
  always_comb begin
    mx  = {{2{m[WIDTH-1]}}, m};
    sum = acc;
`ifdef MULTDIV_RADIX4_EN
    case ({q[1:0], qm1})
      3'b001, 3'b010: sum = acc + mx;
      3'b011:         sum = acc + (mx <<< 1);
      3'b100:         sum = acc - (mx <<< 1);
      3'b101, 3'b110: sum = acc - mx;
      default:        sum = acc;
    endcase
    acc_mul = sum >>> 2;
    q_mul   = {sum[1:0], q[WIDTH-1:2]};
    qm1_mul = q[1];
`else
    case ({q[0], qm1})
      2'b01:   sum = acc + mx;
      2'b10:   sum = acc - mx;
      default: sum = acc;
    endcase
    acc_mul = sum >>> 1;
    q_mul   = {sum[0], q[WIDTH-1:1]};
    qm1_mul = q[0];
`endif
    // Product overflows when the high word is not the sign extension of the low word.
    mul_exc = (acc_mul[WIDTH-1:0] != {WIDTH{q_mul[WIDTH-1]}});
  end

  // Restoring divide step on magnitudes: acc holds the partial remainder, q the
  // dividend shifting out / quotient shifting in.
  always_comb begin
    rem_sh = {acc[WIDTH-1:0], q[WIDTH-1]};
    diff   = rem_sh - {1'b0, m};
    if (!diff[WIDTH]) begin
      acc_div = {1'b0, diff};
      q_div   = {q[WIDTH-2:0], 1'b1};
    end else begin
      acc_div = {1'b0, rem_sh};
      q_div   = {q[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      state          <= IDLE;
      op             <= OP_MUL;
      acc            <= '0;
      q              <= '0;
      qm1            <= 1'b0;
      m              <= '0;
      neg            <= 1'b0;
      div_ovf        <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      if (start) begin
        acc <= '0;
        qm1 <= 1'b0;
        if (ctrl_MULT) begin
          op    <= OP_MUL;
          m     <= data_operandA;
          q     <= data_operandB;
          state <= RUN;
          busy  <= 1'b1;
        end else begin
          op      <= OP_DIV;
          m       <= mag(data_operandB);
          q       <= mag(data_operandA);
          neg     <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
          div_ovf <= (data_operandA == INT_MIN) && (data_operandB == '1);
          if (data_operandB == '0) begin
            // Divide by zero skips the iterations entirely.
            state          <= DONE;
            busy           <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b1;
            data_resultRDY <= 1'b1;
          end else begin
            state <= RUN;
            busy  <= 1'b1;
          end
        end
      end else begin
        case (state)
          RUN: begin
            if (op == OP_MUL) begin
              acc <= acc_mul;
              q   <= q_mul;
              qm1 <= qm1_mul;
              if (tc) begin
                state          <= DONE;
                busy           <= 1'b0;
                data_result    <= q_mul;
                data_exception <= mul_exc;
                data_resultRDY <= 1'b1;
              end
            end else begin
              acc <= acc_div;
              q   <= q_div;
              if (tc) state <= FIX;
            end
          end
          FIX: begin
            // Quotient sign; INT_MIN / -1 yields magnitude 2^31 which reads back as INT_MIN.
            state          <= DONE;
            busy           <= 1'b0;
            data_result    <= neg ? -q : q;
            data_exception <= div_ovf;
            data_resultRDY <= 1'b1;
          end
          DONE:    state <= IDLE;
          default: ;
        endcase
      end
    end
  end
endmodule
